cmp_flag_unit: RTL and testbench

- Receive side of the compare path. Accepts the 16-bit zero-extended compare word from the datapath through a valid/ready handshake.
- Checks that bits [15:2] are zero, narrows the word back to the 2-bit compare code and holds that code in a flag register.
- Answers registered branch-condition queries from the control unit. Out-of-range words are reported through a sticky error state and a saturating error counter.

---
 rtl/cmp_pkg.sv | 35 +++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/cmp_flag_unit.sv | 144 ++++++++++++++
 tb/tb_cmp_flag_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-flag path.
// Contents: compare code encodings, branch condition encodings,
// FSM state type, compare word width and a word legality helper.
package cmp_pkg;

  localparam int CMP_WORD_W = 16;

  // 2-bit compare codes produced by the datapath
  localparam logic [1:0] CMP_EQ    = 2'b00;
  localparam logic [1:0] CMP_LT    = 2'b01;
  localparam logic [1:0] CMP_GT    = 2'b10;
  localparam logic [1:0] CMP_UNORD = 2'b11;

  // Branch condition codes issued by the control unit
  localparam logic [2:0] BR_EQ     = 3'b000;
  localparam logic [2:0] BR_NE     = 3'b001;
  localparam logic [2:0] BR_LT     = 3'b010;
  localparam logic [2:0] BR_GE     = 3'b011;
  localparam logic [2:0] BR_GT     = 3'b100;
  localparam logic [2:0] BR_LE     = 3'b101;
  localparam logic [2:0] BR_ALWAYS = 3'b110;
  localparam logic [2:0] BR_NEVER  = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_VALID = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  // A compare word is legal only when everything above the 2-bit code is zero
  function automatic logic word_legal(input logic [CMP_WORD_W-1:0] word);
    return (word[CMP_WORD_W-1:2] == {(CMP_WORD_W-2){1'b0}});
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   code  - 2-bit compare code (EQ/LT/GT/UNORD)
//   cond  - 3-bit branch condition
//   taken - 1 when the condition holds for the code
// UNORD falls out naturally: it matches none of EQ/LT/GT, so only
// NE and ALWAYS evaluate true for it.
module branch_cond_eval
  import cmp_pkg::*;
(
  input  logic [1:0] code,
  input  logic [2:0] cond,
  output logic       taken
);

  // Decode the condition against the compare code
  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_EQ:     taken = (code == CMP_EQ);
      BR_NE:     taken = (code != CMP_EQ);
      BR_LT:     taken = (code == CMP_LT);
      BR_GE:     taken = (code == CMP_EQ) || (code == CMP_GT);
      BR_GT:     taken = (code == CMP_GT);
      BR_LE:     taken = (code == CMP_EQ) || (code == CMP_LT);
      BR_ALWAYS: taken = 1'b1;
      BR_NEVER:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_flag_unit.sv
// Receive side of the compare path.
// Accepts a zero-extended compare word over cmp_valid/cmp_ready, checks the
// upper bits are zero, stores the 2-bit code in the flag register and answers
// branch-condition queries with a registered one-cycle br_ack pulse.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   cmp_valid/ready/word   - compare word handshake
//   br_req/br_cond         - branch query (held until br_ack)
//   br_ack/br_taken/br_err - registered query answer
//   flag                   - current flag register
//   err/err_clr            - sticky range-error state and its clear
//   err_cnt                - saturating count of rejected words
module cmp_flag_unit
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmp_valid,
  output logic                  cmp_ready,
  input  logic [CMP_WORD_W-1:0] cmp_word,
  input  logic                  br_req,
  input  logic [2:0]            br_cond,
  output logic                  br_ack,
  output logic                  br_taken,
  output logic                  br_err,
  output logic [1:0]            flag,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       flag_r;
  logic [1:0]       flag_nxt_s;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] err_cnt_nxt_s;
  logic             br_ack_r;
  logic             br_taken_r;
  logic             br_err_r;
  logic             answer_s;
  logic             taken_nxt_s;
  logic             berr_nxt_s;
  logic             eval_taken_s;

  branch_cond_eval u_eval (
    .code  (flag_r),
    .cond  (br_cond),
    .taken (eval_taken_s)
  );

  assign cmp_ready = (state_r != ST_ERROR);
  assign err       = (state_r == ST_ERROR);
  assign flag      = flag_r;
  assign err_cnt   = err_cnt_r;
  assign br_ack    = br_ack_r;
  assign br_taken  = br_taken_r;
  assign br_err    = br_err_r;

  // State, flag and error-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      flag_r    <= 2'b00;
      err_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      flag_r    <= flag_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
    end
  end

  // Next-state: word accept/reject and error clear
  always_comb begin
    state_nxt_s   = state_r;
    flag_nxt_s    = flag_r;
    err_cnt_nxt_s = err_cnt_r;
    case (state_r)
      ST_EMPTY, ST_VALID: begin
        if (cmp_valid) begin
          if (word_legal(cmp_word)) begin
            state_nxt_s = ST_VALID;
            flag_nxt_s  = cmp_word[1:0];
          end else begin
            state_nxt_s = ST_ERROR;
            if (err_cnt_r != CNT_MAX) begin
              err_cnt_nxt_s = err_cnt_r + CNT_ONE;
            end else begin
              err_cnt_nxt_s = err_cnt_r;
            end
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ERROR: begin
        // ready is low here, so no word can be taken on the clearing edge
        if (err_clr) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Query decision; the ack cycle itself masks br_req so a still-high
  // request is not answered twice. Uses pre-edge state and flag.
  always_comb begin
    answer_s    = br_req && !br_ack_r &&
                  ((state_r == ST_VALID) || (state_r == ST_ERROR));
    taken_nxt_s = 1'b0;
    berr_nxt_s  = 1'b0;
    if (answer_s) begin
      taken_nxt_s = (state_r == ST_VALID) && eval_taken_s;
      berr_nxt_s  = (state_r == ST_ERROR);
    end else begin
      taken_nxt_s = 1'b0;
      berr_nxt_s  = 1'b0;
    end
  end

  // Registered query answer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_ack_r   <= 1'b0;
      br_taken_r <= 1'b0;
      br_err_r   <= 1'b0;
    end else begin
      br_ack_r   <= answer_s;
      br_taken_r <= taken_nxt_s;
      br_err_r   <= berr_nxt_s;
    end
  end

endmodule

// File: tb/tb_cmp_flag_unit.sv
// Directed self-checking bench for cmp_flag_unit.
module tb_cmp_flag_unit;

  logic        clk;
  logic        reset;
  logic        cmp_valid;
  logic        cmp_ready;
  logic [15:0] cmp_word;
  logic        br_req;
  logic [2:0]  br_cond;
  logic        br_ack;
  logic        br_taken;
  logic        br_err;
  logic [1:0]  flag;
  logic        err;
  logic        err_clr;
  logic [7:0]  err_cnt;

  int total;
  int bad;

  cmp_flag_unit #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmp_valid (cmp_valid),
    .cmp_ready (cmp_ready),
    .cmp_word  (cmp_word),
    .br_req    (br_req),
    .br_cond   (br_cond),
    .br_ack    (br_ack),
    .br_taken  (br_taken),
    .br_err    (br_err),
    .flag      (flag),
    .err       (err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    cmp_valid = 1'b1;
    cmp_word  = w;
    tick();
    cmp_valid = 1'b0;
    cmp_word  = 16'h0000;
  endtask

  task automatic do_query(input string tag, input logic [2:0] c,
                          input logic exp_t, input logic exp_e);
    int n;
    n = 0;
    br_req  = 1'b1;
    br_cond = c;
    do begin
      tick();
      n++;
    end while (!br_ack && n < 8);
    chk({tag, "_ack"}, br_ack, 1);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_taken"}, br_taken, exp_t);
    chk({tag, "_err"}, br_err, exp_e);
    br_req = 1'b0;
    tick();
    chk({tag, "_single"}, {br_ack, br_taken, br_err}, 0);
  endtask

  logic [7:0] pat [4];
  logic [7:0] row;
  int         acks;

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    cmp_valid = 1'b0;
    cmp_word  = 16'h0000;
    br_req    = 1'b0;
    br_cond   = 3'b000;
    err_clr   = 1'b0;
    // taken pattern per code, bit i = cond i
    pat[0] = 8'h69;
    pat[1] = 8'h66;
    pat[2] = 8'h5A;
    pat[3] = 8'h42;

    tick();
    tick();
    reset = 1'b0;
    chk("rst_flag", flag, 0);
    chk("rst_ack", {br_ack, br_taken, br_err}, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_ready", cmp_ready, 1);
    chk("rst_err", err, 0);

    // first legal word and LT query
    send_word(16'h0001);
    chk("w1_flag", flag, 1);
    chk("w1_ready", cmp_ready, 1);
    do_query("q_lt", 3'b010, 1'b1, 1'b0);

    // err_clr outside ERROR is ignored
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_noerr", err, 0);
    do_query("q_after_clr", 3'b010, 1'b1, 1'b0);

    // every code against every condition
    for (int c = 0; c < 4; c++) begin
      send_word(16'(c));
      chk($sformatf("flag_%0d", c), flag, c);
      row = pat[c];
      for (int k = 0; k < 8; k++) begin
        do_query($sformatf("q_c%0d_k%0d", c, k), 3'(k), row[k], 1'b0);
      end
    end

    // illegal word -> ERROR, flag stays 11
    send_word(16'h0104);
    chk("il_err", err, 1);
    chk("il_ready", cmp_ready, 0);
    chk("il_flag", flag, 3);
    chk("il_cnt", err_cnt, 1);
    do_query("q_error", 3'b110, 1'b0, 1'b1);
    // word offered in ERROR is not taken
    send_word(16'h0000);
    chk("err_noacc_flag", flag, 3);
    chk("err_noacc_err", err, 1);
    err_clr   = 1'b1;
    cmp_valid = 1'b1;
    cmp_word  = 16'h0001;
    tick();
    err_clr   = 1'b0;
    cmp_valid = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_ready", cmp_ready, 1);
    chk("clr_flag", flag, 3);
    chk("clr_cnt", err_cnt, 1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      send_word(16'h8000);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      if (i == 99) chk("cnt_101", err_cnt, 101);
      if (i == 253) chk("cnt_255", err_cnt, 255);
    end
    chk("cnt_sat", err_cnt, 255);
    chk("sat_err", err, 0);

    // query waits in EMPTY
    br_req  = 1'b1;
    br_cond = 3'b000;
    acks    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (br_ack) acks++;
    end
    chk("empty_noack", acks, 0);
    send_word(16'h0000);
    chk("empty_accept_noack", br_ack, 0);
    tick();
    chk("empty_late_ack", br_ack, 1);
    chk("empty_late_taken", br_taken, 1);
    br_req = 1'b0;
    tick();
    chk("empty_single", br_ack, 0);

    // same-edge accept + query uses old flag
    send_word(16'h0001);
    cmp_valid = 1'b1;
    cmp_word  = 16'h0002;
    br_req    = 1'b1;
    br_cond   = 3'b100;
    tick();
    cmp_valid = 1'b0;
    chk("same_ack", br_ack, 1);
    chk("same_taken_old", br_taken, 0);
    chk("same_flag_new", flag, 2);
    br_req = 1'b0;
    tick();
    do_query("q_gt_new", 3'b100, 1'b1, 1'b0);

    // reset mid-query
    br_req  = 1'b1;
    br_cond = 3'b110;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_q_flag", flag, 0);
    chk("arst_q_ack", {br_ack, br_taken, br_err}, 0);
    chk("arst_q_cnt", err_cnt, 0);
    tick();
    br_req = 1'b0;
    reset  = 1'b0;
    tick();
    chk("arst_q_noack", br_ack, 0);

    // reset mid-ERROR
    send_word(16'hFFFF);
    chk("pre_arst_err", err, 1);
    chk("pre_arst_cnt", err_cnt, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_e_err", err, 0);
    chk("arst_e_ready", cmp_ready, 1);
    chk("arst_e_cnt", err_cnt, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
